// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// MEM-stage data-memory access controller. It takes the load or store held in
// EX/MEM and runs a valid/ready request and a response handshake to a
// variable-latency data memory. While the access is in flight it freezes the
// front of the pipeline with o_mem_stall. It hands load results to MEM/WB
// with a one-cycle o_load_valid pulse.
//
// Parameters
//   TIMEOUT            max WAIT cycles before the access is aborted (1..65535)
//
// Ports
//   clk                single clock, rising edge
//   rst_n              asynchronous active-low reset
//   i_ex_mem_memread   EX/MEM instruction is a load
//   i_ex_mem_memwrite  EX/MEM instruction is a store (wins if both are set)
//   i_ex_mem_addr      byte address, word accesses only
//   i_ex_mem_wdata     store data
//   o_dmem_req_valid   request valid (REQ state)
//   i_dmem_req_ready   memory accepts the request
//   o_dmem_req_we      1 = write, 0 = read
//   o_dmem_req_addr    registered request address
//   o_dmem_req_wdata   registered write data
//   i_dmem_resp_valid  read response or write ack
//   i_dmem_resp_rdata  read data
//   o_mem_stall        freeze PC, IF/ID, ID/EX, EX/MEM
//   o_load_data        load result for MEM/WB
//   o_load_valid       one-cycle pulse, o_load_data valid
//   o_bus_err          one-cycle pulse on response timeout
//   o_misalign_err     one-cycle pulse on a misaligned access
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex_mem_memread,
  input  logic        i_ex_mem_memwrite,
  input  logic [31:0] i_ex_mem_addr,
  input  logic [31:0] i_ex_mem_wdata,
  output logic        o_dmem_req_valid,
  input  logic        i_dmem_req_ready,
  output logic        o_dmem_req_we,
  output logic [31:0] o_dmem_req_addr,
  output logic [31:0] o_dmem_req_wdata,
  input  logic        i_dmem_resp_valid,
  input  logic [31:0] i_dmem_resp_rdata,
  output logic        o_mem_stall,
  output logic [31:0] o_load_data,
  output logic        o_load_valid,
  output logic        o_bus_err,
  output logic        o_misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The counter holds WAIT cycles already spent; reaching CNT_LAST without a
  // response means this is the TIMEOUT-th WAIT cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_req_we;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [15:0] r_cnt;
  logic        r_err;
  logic [31:0] r_load_data;

  logic w_pending;
  logic w_aligned;
  logic w_start;
  logic w_misalign;
  logic w_cnt_last;

  assign w_pending  = i_ex_mem_memread | i_ex_mem_memwrite;
  assign w_aligned  = (i_ex_mem_addr[1:0] == 2'b00);
  assign w_start    = (r_state == S_IDLE) & w_pending & w_aligned;
  assign w_misalign = (r_state == S_IDLE) & w_pending & ~w_aligned;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs. DONE always returns to IDLE without
  // looking at EX/MEM, because EX/MEM only advances on the DONE edge.
  // Stall and the IDLE-cycle error/valid pulses are combinational on the
  // EX/MEM inputs, so they are gated with rst_n to stay quiet during reset.
  always_comb begin
    w_next           = r_state;
    o_dmem_req_valid = 1'b0;
    o_mem_stall      = 1'b0;
    o_load_valid     = 1'b0;
    o_bus_err        = 1'b0;
    o_misalign_err   = 1'b0;
    o_load_data      = r_load_data;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next      = S_REQ;
          o_mem_stall = rst_n;
        end
        if (w_misalign) begin
          o_misalign_err = rst_n;
          o_load_valid   = rst_n & ~i_ex_mem_memwrite;
          o_load_data    = 32'h0;
        end
      end
      S_REQ: begin
        o_dmem_req_valid = 1'b1;
        o_mem_stall      = 1'b1;
        if (i_dmem_req_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        o_mem_stall = 1'b1;
        if (i_dmem_resp_valid || w_cnt_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_load_valid = ~r_req_we;
        o_bus_err    = r_err;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request registers, timeout counter, error flag and load result.
  // A response in WAIT takes priority over the timeout in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_we    <= 1'b0;
      r_req_addr  <= 32'h0;
      r_req_wdata <= 32'h0;
      r_cnt       <= 16'h0;
      r_err       <= 1'b0;
      r_load_data <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req_we    <= i_ex_mem_memwrite;
            r_req_addr  <= i_ex_mem_addr;
            r_req_wdata <= i_ex_mem_wdata;
            r_err       <= 1'b0;
          end
        end
        S_REQ: begin
          if (i_dmem_req_ready) begin
            r_cnt <= 16'h0;
          end
        end
        S_WAIT: begin
          if (i_dmem_resp_valid) begin
            if (!r_req_we) begin
              r_load_data <= i_dmem_resp_rdata;
            end
          end else if (w_cnt_last) begin
            r_err <= 1'b1;
            if (!r_req_we) begin
              r_load_data <= 32'h0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_dmem_req_we    = r_req_we;
  assign o_dmem_req_addr  = r_req_addr;
  assign o_dmem_req_wdata = r_req_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Bench for dmem_access_ctrl with TIMEOUT = 4. Each access is played cycle by
// cycle: the bench acts as EX/MEM (advancing when stall is low) and as the
// data memory (ready after a chosen delay, response a chosen number of
// cycles after accept). The per-cycle stall / request / pulse patterns are
// collected as bit masks and compared with masks derived from the latency
// rules. Load data comes from a reference word memory.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam int TMO      = 4;
  localparam int NO_RESP  = 99;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [31:0] exAddr;
  logic [31:0] exWdata;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        memStall;
  logic [31:0] loadData;
  logic        loadValid;
  logic        busErr;
  logic        misalignErr;

  int errors = 0;
  int checks = 0;

  bit [31:0] envMem [bit [29:0]];
  bit [31:0] refMem [bit [29:0]];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;
    int          lat;
    bit          preload;
    logic [31:0] memData;
    int          expStall;
    int          expReq;
    bit          expLv;
    logic [31:0] expLd;
    bit          expBerr;
    bit          expMis;
  } vec_t;

  vec_t vecs [12];

  dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_ex_mem_memread  (memRead),
    .i_ex_mem_memwrite (memWrite),
    .i_ex_mem_addr     (exAddr),
    .i_ex_mem_wdata    (exWdata),
    .o_dmem_req_valid  (reqValid),
    .i_dmem_req_ready  (reqReady),
    .o_dmem_req_we     (reqWe),
    .o_dmem_req_addr   (reqAddr),
    .o_dmem_req_wdata  (reqWdata),
    .i_dmem_resp_valid (respValid),
    .i_dmem_resp_rdata (respRdata),
    .o_mem_stall       (memStall),
    .o_load_data       (loadData),
    .o_load_valid      (loadValid),
    .o_bus_err         (busErr),
    .o_misalign_err    (misalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on contents of a word that has never been written.
  function automatic logic [31:0] defWord(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_5A00;
  endfunction

  function automatic logic [31:0] envRead(input logic [31:0] a);
    if (envMem.exists(a[31:2])) return envMem[a[31:2]];
    return defWord(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a[31:2])) return refMem[a[31:2]];
    return defWord(a);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plays one EX/MEM instruction until the pipeline advances (stall low at an
  // edge). Entry and exit are 1 time unit after a rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int rdy, input int lat,
                               output logic [63:0] stallMask, output logic [63:0] reqMask,
                               output logic [63:0] lvMask, output logic [63:0] berrMask,
                               output logic [63:0] misMask, output logic [31:0] ldAtPulse,
                               output int fieldErrs, output bit hung);
    int reqCycles;
    int since;
    bit accepted;
    bit doneNow;
    bit sawValid;
    bit sawAccept;
    logic [31:0] acceptAddr;
    memRead   = rd;
    memWrite  = wr;
    exAddr    = addr;
    exWdata   = wdata;
    reqCycles = 0;
    since     = 0;
    accepted  = 1'b0;
    acceptAddr = 32'h0;
    stallMask = '0;
    reqMask   = '0;
    lvMask    = '0;
    berrMask  = '0;
    misMask   = '0;
    ldAtPulse = 32'h0;
    fieldErrs = 0;
    hung      = 1'b1;
    for (int c = 0; c < 64; c++) begin
      reqReady  = reqValid && (reqCycles >= rdy);
      respValid = accepted && (since == lat);
      respRdata = respValid ? envRead(acceptAddr) : $urandom();
      @(negedge clk);
      stallMask[c] = memStall;
      reqMask[c]   = reqValid;
      lvMask[c]    = loadValid;
      berrMask[c]  = busErr;
      misMask[c]   = misalignErr;
      if (loadValid) ldAtPulse = loadData;
      if (reqValid) begin
        if (reqAddr !== addr || reqWe !== wr || (wr && reqWdata !== wdata)) fieldErrs++;
      end
      if (respValid && reqWe) envMem[reqAddr[31:2]] = reqWdata;
      doneNow   = !memStall;
      sawValid  = reqValid;
      sawAccept = reqValid && reqReady;
      if (sawAccept) acceptAddr = reqAddr;
      @(posedge clk);
      #1;
      if (sawValid) reqCycles++;
      if (sawAccept) begin
        accepted = 1'b1;
        since    = 1;
      end else if (accepted) begin
        since++;
      end
      if (doneNow) begin
        hung = 1'b0;
        break;
      end
    end
    reqReady  = 1'b0;
    respValid = 1'b0;
  endtask

  // Reference outcome of one access from the controller's rules.
  task automatic modelExpect(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int rdy, input int lat,
                             output vec_t v);
    bit timedOut;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdy = rdy; v.lat = lat;
    v.preload = 1'b0; v.memData = 32'h0;
    timedOut = (lat > TMO);
    if (addr[1:0] != 2'b00) begin
      v.expStall = 0; v.expReq = 0; v.expLv = rd && !wr; v.expLd = 32'h0;
      v.expBerr = 1'b0; v.expMis = 1'b1;
    end else begin
      v.expStall = 2 + rdy + (timedOut ? TMO : lat);
      v.expReq   = rdy + 1;
      v.expLv    = !wr;
      v.expLd    = (timedOut || wr) ? 32'h0 : refRead(addr);
      v.expBerr  = timedOut;
      v.expMis   = 1'b0;
    end
  endtask

  task automatic runVec(input string tag, input vec_t v);
    logic [63:0] stallM, reqM, lvM, berrM, misM;
    logic [31:0] ld;
    int fe;
    bit hung;
    logic [63:0] one;
    one = 64'd1;
    if (v.preload) begin
      envMem[v.addr[31:2]] = v.memData;
      refMem[v.addr[31:2]] = v.memData;
    end
    applyStimulus(v.rd, v.wr, v.addr, v.wdata, v.rdy, v.lat,
                  stallM, reqM, lvM, berrM, misM, ld, fe, hung);
    checkOutput({tag, ".finished"}, {63'h0, hung}, 64'h0);
    checkOutput({tag, ".stall"}, stallM, (one << v.expStall) - one);
    checkOutput({tag, ".reqValid"}, reqM, ((one << v.expReq) - one) << 1);
    checkOutput({tag, ".loadValid"}, lvM, v.expLv ? (one << v.expStall) : 64'h0);
    checkOutput({tag, ".busErr"}, berrM, v.expBerr ? (one << v.expStall) : 64'h0);
    checkOutput({tag, ".misalign"}, misM, v.expMis ? one : 64'h0);
    checkOutput({tag, ".reqFields"}, 64'(fe), 64'h0);
    if (v.expLv) checkOutput({tag, ".loadData"}, {32'h0, ld}, {32'h0, v.expLd});
    if (v.wr && v.addr[1:0] == 2'b00 && v.lat <= TMO) refMem[v.addr[31:2]] = v.wdata;
  endtask

  // Idle cycles with nothing pending; stray responses must be ignored.
  task automatic idleCycles(input string tag, input int n, input bit stray);
    int bad;
    bad = 0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    for (int c = 0; c < n; c++) begin
      respValid = stray;
      respRdata = 32'hBADB_AD00 ^ 32'($urandom_range(0, 255));
      @(negedge clk);
      if (memStall || loadValid || busErr || misalignErr || reqValid) bad++;
      @(posedge clk);
      #1;
    end
    respValid = 1'b0;
    checkOutput({tag, ".quiet"}, 64'(bad), 64'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    logic rd;
    logic wr;
    logic [31:0] addr;
    int kind;
    int lat;

    //           rd    wr    addr          wdata         rdy lat      pre   memData       stl req lv    ld            berr  mis
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        0, 1,       1'b1, 32'hDEAD_BEEF, 3,  1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 2,       1'b0, 32'h0,        7,  4, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        0, 3,       1'b0, 32'h0,        5,  1, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,        0, 1,       1'b0, 32'h0,        0,  0, 1'b1, 32'h0,        1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0023, 32'hFFFF_0000, 0, 1,       1'b0, 32'h0,        0,  0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1, TMO,     1'b0, 32'h0,        7,  2, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        2, 1,       1'b0, 32'h0,        5,  3, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 1,       1'b1, 32'h1111_1111, 3,  1, 1'b1, 32'h1111_1111, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        0, 1,       1'b1, 32'h2222_2222, 3,  1, 1'b1, 32'h2222_2222, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        0, NO_RESP, 1'b1, 32'hAAAA_5555, 6,  1, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,        0, TMO + 1, 1'b1, 32'h7777_7777, 6,  1, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        0, 2,       1'b1, 32'h5EED_1234, 4,  1, 1'b1, 32'h5EED_1234, 1'b0, 1'b0};

    // Reset with a misaligned load pending: every output must stay low.
    rst_n     = 1'b0;
    memRead   = 1'b1;
    memWrite  = 1'b0;
    exAddr    = 32'h0000_0102;
    exWdata   = 32'h0;
    reqReady  = 1'b0;
    respValid = 1'b0;
    respRdata = 32'h0;
    #12;
    checkOutput("reset.misalignPending",
                {reqValid, reqWe, memStall, loadValid, busErr, misalignErr, reqAddr, loadData},
                '0);
    exAddr = 32'h0000_0100;
    #3;
    checkOutput("reset.alignedPending", {63'h0, memStall}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i <= 10; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Late response arriving while idle after the timeout.
    idleCycles("staleIdle", 2, 1'b1);
    checkOutput("staleIdle.loadData", {32'h0, loadData}, 64'h0);

    // Reset asserted while waiting for a response.
    memRead  = 1'b1;
    memWrite = 1'b0;
    exAddr   = 32'h0000_0100;
    @(negedge clk);
    @(posedge clk);
    #1;
    reqReady = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reqReady = 1'b0;
    @(negedge clk);
    checkOutput("rstWait.inWait", {62'h0, memStall, reqValid}, 64'h2);
    rst_n = 1'b0;
    #1;
    checkOutput("rstWait.outputsLow",
                {reqValid, reqWe, memStall, loadValid, busErr, misalignErr, reqAddr, reqWdata, loadData},
                '0);
    respValid = 1'b1;
    respRdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    checkOutput("rstWait.heldLow", {60'h0, memStall, reqValid, loadValid, busErr}, 64'h0);
    @(posedge clk);
    #1;
    respValid = 1'b0;
    rst_n     = 1'b1;
    runVec("vec11", vecs[11]);

    // Randomized accesses checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      lat  = ($urandom_range(0, 5) == 0) ? NO_RESP : $urandom_range(1, TMO);
      modelExpect(rd, wr, addr, $urandom(), $urandom_range(0, 3), lat, rv);
      runVec($sformatf("rand%0d", n), rv);
      if ($urandom_range(0, 3) == 0) begin
        idleCycles($sformatf("rand%0d.gap", n), $urandom_range(1, 2), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

MEM-stage data-memory access controller for the 5-stage pipeline. It takes the load/store in the EX/MEM register and runs a valid/ready request plus response handshake to a variable-latency data memory. Until the access completes it holds the whole pipeline with `mem_stall`. The ID-stage load-use hazard logic raises stalls from the decode side; this block raises them from the memory side. It delivers load data to MEM/WB with a one-cycle valid pulse.

## Interface
- `TIMEOUT`, default 255: maximum WAIT cycles before the access is aborted with `bus_err`; legal range 1–65535.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ex_mem_memread` input 1: the instruction in EX/MEM is a load.
- `ex_mem_memwrite` input 1: the instruction in EX/MEM is a store.
- `ex_mem_addr` input 32: byte address; word accesses only.
- `ex_mem_wdata` input 32: store data.
- `dmem_req_valid` output 1: request valid.
- `dmem_req_ready` input 1: memory accepts the request.
- `dmem_req_we` output 1: 1 = write, 0 = read.
- `dmem_req_addr` output 32: registered request address.
- `dmem_req_wdata` output 32: registered write data.
- `dmem_resp_valid` input 1: response or write-ack valid.
- `dmem_resp_rdata` input 32: read data.
- `mem_stall` output 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `load_data` output 32: registered load result for MEM/WB.
- `load_valid` output 1: one-cycle pulse, `load_data` valid.
- `bus_err` output 1: one-cycle pulse on timeout.
- `misalign_err` output 1: one-cycle pulse on `addr[1:0] != 0`.

## Operation
- There are four states: IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- An access is pending when `memread | memwrite`. If both are set, the access is a write.
- **IDLE, pending and aligned:**
  - Latch addr, wdata and we into the request registers.
  - Assert `mem_stall` combinationally in this cycle.
  - Next state is REQ.
- **IDLE, pending and misaligned:**
  - No request is issued and `mem_stall` stays 0.
  - Pulse `misalign_err` in this cycle.
  - For a load, also pulse `load_valid` with `load_data` = 0.
  - Stay in IDLE.
- **REQ:** `dmem_req_valid` = 1 and the request fields are held stable. On `valid & ready`, go to WAIT and clear the timeout counter.
- **WAIT:**
  - On `dmem_resp_valid`, go to DONE; for a read, capture `dmem_resp_rdata` into `load_data`.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT - 1` with no response, go to DONE with an error flag set and `load_data` = 0.
- **DONE:**
  - `mem_stall` = 0, so the pipeline advances on this edge.
  - Pulse `load_valid` for a read and `bus_err` if the error flag is set.
  - Next state is IDLE, without re-sampling EX/MEM in this cycle.
- `mem_stall` = `(IDLE & pending & aligned) | REQ | WAIT`.
- Memory rules:
  - The memory must not assert `dmem_resp_valid` in the accept cycle.
  - `dmem_resp_valid` is ignored in IDLE, REQ and DONE; a stale response after reset or after a timeout is dropped.
- Writes wait for the ack just like reads. `load_valid` never pulses for a write.

## Timing
- Reset values: `dmem_req_valid`, `dmem_req_we`, `mem_stall`, `load_valid`, `bus_err`, `misalign_err` = 0; `dmem_req_addr`, `dmem_req_wdata`, `load_data` = 0; counter = 0.
- During reset, `mem_stall` is forced to 0 regardless of the inputs.
- Reset is asynchronous and may hit mid-operation. The state returns to IDLE immediately and an outstanding memory transaction is abandoned.
- Latency, with memory ready in its first REQ cycle and response L ≥ 1 cycles after accept:
  - `mem_stall` is high for 2+L cycles.
  - DONE, and therefore the `load_valid` pulse, falls in cycle 2+L counting the detect cycle as 0.
- Each cycle `dmem_req_ready` is low in REQ extends the stall by one cycle.
- The `TIMEOUT` bound is counted from the accept edge. DONE with `bus_err` follows TIMEOUT cycles in WAIT.
- Back-to-back accesses: the next access is detected in the cycle after DONE. The minimum gap between requests is 1 idle cycle.

## Test plan
- **Load, ready=1, L=1, addr 0x100, rdata 0xDEADBEEF:**
  - `mem_stall` high exactly 3 cycles.
  - `dmem_req_valid` high 1 cycle with addr 0x100, we 0.
  - `load_valid` pulses once with `load_data` 0xDEADBEEF.
- **Store addr 0x20, wdata 0x12345678, ready delayed 3 cycles, L=2:**
  - `req_valid` held 4 cycles with stable fields and we=1.
  - Stall lasts 7 cycles.
  - No `load_valid`.
- **Load addr 0x102:**
  - `misalign_err` and `load_valid` pulse in the same cycle, with `load_data` 0.
  - No request issued, `mem_stall` never high.
- **TIMEOUT=4, load accepted, no response:**
  - `bus_err` pulses after 4 WAIT cycles and `load_data` = 0.
  - A late `resp_valid` in IDLE is ignored.
- **Reset in WAIT, then reset release:**
  - All outputs are 0 during reset.
  - After release, the state is IDLE and a new load completes normally with the correct data.
- **Two back-to-back loads, 0x0 then 0x4:**
  - Two separate requests with 1 idle cycle between them.
  - Two `load_valid` pulses returning the respective data in order.
